multicycle_control: RTL

Multi-cycle sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback using the instruction decoder's control outputs, and handles the instruction and data memory handshakes. It also owns the PC-update and trap-entry strobes, the memory-timeout watchdog and the retired-instruction counter. It sits between the instruction register/decoder, the memory ports, the register file, the PC register and the CSR file.

---
 rtl/multicycle_control.sv | 138 +++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK, owns memory
// handshakes, PC/trap strobes, the memory-ready watchdog and the retired-instruction counter.
module multicycle_control #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_IMemReady,
    input  logic                     i_DMemReady,
    input  logic                     i_IllegalInstruction,
    input  logic                     i_RegWrite,
    input  logic                     i_MemRead,
    input  logic                     i_MemWrite,
    input  logic                     i_Branch,
    input  logic                     i_Jump,
    input  logic                     i_BranchTaken,
    output logic                     o_IMemRequest,
    output logic                     o_InstrLatchEnable,
    output logic                     o_DMemRead,
    output logic                     o_DMemWrite,
    output logic                     o_RegFileWriteEnable,
    output logic                     o_PcWriteEnable,
    output logic [1:0]               o_PcSource,
    output logic                     o_TrapEnter,
    output logic [3:0]               o_TrapCause,
    output logic                     o_Retired,
    output logic [INSTRET_WIDTH-1:0] o_InstretCount,
    output logic [2:0]               o_State
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

    state_t                   state, nextState;
    logic [CW-1:0]            timeoutCount;
    logic [3:0]               cause, nextCause;
    logic [INSTRET_WIDTH-1:0] instret;
    logic                     timedOut;

    assign timedOut = (MEM_TIMEOUT != 0) && (timeoutCount == TIMEOUT_LAST);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state        <= ST_RESET;
            timeoutCount <= '0;
            cause        <= '0;
            instret      <= '0;
        end else begin
            state <= nextState;
            cause <= nextCause;
            // Counter only runs while stalled on a ready; any other cycle leaves it at 0,
            // so it is already clear on every entry to FETCH or MEM.
            if ((state == ST_FETCH && !i_IMemReady) || (state == ST_MEM && !i_DMemReady))
                timeoutCount <= timeoutCount + 1'b1;
            else
                timeoutCount <= '0;
            if (state == ST_WRITEBACK)
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        nextState            = state;
        nextCause            = cause;
        o_IMemRequest        = 1'b0;
        o_InstrLatchEnable   = 1'b0;
        o_DMemRead           = 1'b0;
        o_DMemWrite          = 1'b0;
        o_RegFileWriteEnable = 1'b0;
        o_PcWriteEnable      = 1'b0;
        o_PcSource           = 2'd0;
        o_TrapEnter          = 1'b0;
        o_TrapCause          = 4'd0;
        o_Retired            = 1'b0;
        case (state)
            ST_RESET: nextState = ST_FETCH;
            ST_FETCH: begin
                o_IMemRequest = 1'b1;
                if (i_IMemReady) begin
                    o_InstrLatchEnable = 1'b1;
                    nextState          = ST_DECODE;
                end else if (timedOut) begin
                    nextState = ST_TRAP;
                    nextCause = 4'd1;
                end
            end
            ST_DECODE: begin
                if (i_IllegalInstruction || (i_MemRead && i_MemWrite)) begin
                    nextState = ST_TRAP;
                    nextCause = 4'd2;
                end else begin
                    nextState = ST_EXECUTE;
                end
            end
            ST_EXECUTE: nextState = (i_MemRead || i_MemWrite) ? ST_MEM : ST_WRITEBACK;
            ST_MEM: begin
                o_DMemRead  = i_MemRead;
                o_DMemWrite = i_MemWrite;
                if (i_DMemReady) begin
                    nextState = ST_WRITEBACK;
                end else if (timedOut) begin
                    nextState = ST_TRAP;
                    nextCause = i_MemRead ? 4'd5 : 4'd7;
                end
            end
            ST_WRITEBACK: begin
                o_RegFileWriteEnable = i_RegWrite;
                o_PcWriteEnable      = 1'b1;
                o_PcSource           = (i_Jump || (i_Branch && i_BranchTaken)) ? 2'd1 : 2'd0;
                o_Retired            = 1'b1;
                nextState            = ST_FETCH;
            end
            ST_TRAP: begin
                o_TrapEnter     = 1'b1;
                o_PcWriteEnable = 1'b1;
                o_PcSource      = 2'd2;
                o_TrapCause     = cause;
                nextState       = ST_FETCH;
            end
            default: nextState = ST_RESET;
        endcase
    end

    assign o_InstretCount = instret;
    assign o_State        = state;

endmodule
